// File: rtl/mem_pkg.sv
// Shared definitions for the multi-port memory: program length, FSM encoding
// and the width helper used to size the initialiser counter.
package mem_pkg;

   localparam int PROGRAM_LENGTH = 5;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/mem_mp_init_if.sv
// Read/write bus of the multi-port memory. Ports are packed flat, port p in
// slice [p*WIDTH +: WIDTH].
interface mem_mp_init_if #(
   parameter int N_RD       = 2,
   parameter int N_WR       = 1,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);
   logic [N_RD*ADDR_WIDTH-1:0] r_addr;
   logic [N_RD*DATA_WIDTH-1:0] r_data;
   logic [N_WR*ADDR_WIDTH-1:0] w_addr;
   logic [N_WR*DATA_WIDTH-1:0] w_data;
   logic [N_WR-1:0]            w_en;

   modport master (output r_addr, w_addr, w_data, w_en, input r_data);
   modport slave  (input r_addr, w_addr, w_data, w_en, output r_data);
endinterface

// File: rtl/mem_init_rom.sv
// Program image used by the initialiser. Assembler-generated word table goes
// in the case below; anything past the program reads as 0.
module mem_init_rom
   import mem_pkg::*;
#(
   parameter int AW = 7,
   parameter int DW = 16
) (
   input  logic [AW-1:0] addr,
   output logic [DW-1:0] word
);

   always_comb begin
      word = '0;
      if (int'(addr) < PROGRAM_LENGTH) begin
         case (int'(addr))
            0:       word = DW'(16'h200F);
            1:       word = DW'(16'hEC18);
            2:       word = DW'(16'h5A5A);
            3:       word = DW'(16'h3C7E);
            4:       word = DW'(16'h0F0F);
            default: word = '0;
         endcase
      end
   end

endmodule

// File: rtl/mem_mp_init.sv
// Parametrised N_RD-read / N_WR-write memory with a sequential image loader,
// highest-port-wins write priority and a sticky out-of-range flag.
module mem_mp_init
   import mem_pkg::*;
#(
   parameter int N_ELEMENTS = 128,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int N_RD       = 2,
   parameter int N_WR       = 1,
   parameter int RD_LATENCY = 0
) (
   input  logic          clk,
   input  logic          rst,
   mem_mp_init_if.slave  bus,
   output logic          init_done,
   output logic          err_oob
);

   localparam int CNT_W = (N_ELEMENTS > 1) ? clog2(N_ELEMENTS) : 1;
   localparam logic [ADDR_WIDTH:0] N_LIM = (ADDR_WIDTH+1)'(N_ELEMENTS);
   localparam logic [CNT_W-1:0]    LAST  = CNT_W'(N_ELEMENTS - 1);

   logic [DATA_WIDTH-1:0] mem_q [N_ELEMENTS];
   logic [DATA_WIDTH-1:0] mem_d [N_ELEMENTS];

   state_e           state_q, state_d;
   logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
   logic             init_done_q, init_done_d;
   logic             err_oob_q, err_oob_d;
   logic [DATA_WIDTH-1:0] rom_word;

   logic [N_RD-1:0]       rd_oob;
   logic [N_RD*DATA_WIDTH-1:0] rd_word;
   logic [N_WR-1:0]       wr_oob;
   logic [ADDR_WIDTH-1:0] wa [N_WR];
   logic [DATA_WIDTH-1:0] wd [N_WR];

   mem_init_rom #(.AW(CNT_W), .DW(DATA_WIDTH)) u_rom (
      .addr (init_cnt_q),
      .word (rom_word)
   );

   // Reads return 0 until the array has been fully loaded.
   for (genvar p = 0; p < N_RD; p++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      assign ra        = bus.r_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign rd_oob[p] = {1'b0, ra} >= N_LIM;
      assign rd_word[p*DATA_WIDTH +: DATA_WIDTH] =
         (init_done_q && !rd_oob[p]) ? mem_q[ra[CNT_W-1:0]] : '0;
   end

   for (genvar j = 0; j < N_WR; j++) begin : g_wr
      assign wa[j]     = bus.w_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
      assign wd[j]     = bus.w_data[j*DATA_WIDTH +: DATA_WIDTH];
      assign wr_oob[j] = {1'b0, wa[j]} >= N_LIM;
   end

   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      init_done_d = init_done_q;
      err_oob_d   = err_oob_q;
      case (state_q)
         INIT: begin
            if (init_cnt_q == LAST) begin
               state_d     = READY;
               init_done_d = 1'b1;
            end else begin
               init_cnt_d = init_cnt_q + 1'b1;
            end
         end
         READY: begin
            if (|rd_oob || |(wr_oob & bus.w_en)) err_oob_d = 1'b1;
         end
         default: state_d = INIT;
      endcase
   end

   // Ascending port loop: the last matching assignment wins, so the
   // highest-numbered port takes a same-address conflict.
   always_comb begin
      mem_d = mem_q;
      if (rst) begin
         if (state_q == INIT) begin
            mem_d[init_cnt_q] = rom_word;
         end else begin
            for (int j = 0; j < N_WR; j++)
               if (bus.w_en[j] && !wr_oob[j]) mem_d[wa[j][CNT_W-1:0]] = wd[j];
         end
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (!rst) begin
         state_q     <= INIT;
         init_cnt_q  <= '0;
         init_done_q <= 1'b0;
         err_oob_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         init_done_q <= init_done_d;
         err_oob_q   <= err_oob_d;
      end
   end

   if (RD_LATENCY == 0) begin : g_comb_rd
      assign bus.r_data = rd_word;
   end else begin : g_reg_rd
      logic [N_RD*DATA_WIDTH-1:0] r_data_q, r_data_d;
      assign r_data_d = rd_word;
      always_ff @(posedge clk) begin
         if (!rst) r_data_q <= '0;
         else      r_data_q <= r_data_d;
      end
      assign bus.r_data = r_data_q;
   end

   assign init_done = init_done_q;
   assign err_oob   = err_oob_q;

endmodule

// File: tb/tb_mem_mp_init.sv
// Drives a combinational-read and a registered-read instance with identical
// stimulus and checks both against a word-level reference model.
module tb_mem_mp_init;
   localparam int N  = 16;
   localparam int AW = 16;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [AW-1:0] ra [2];
   logic [AW-1:0] wa [2];
   logic [DW-1:0] wd [2];
   logic [1:0]    we;

   mem_mp_init_if #(.N_RD(2), .N_WR(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
   mem_mp_init_if #(.N_RD(2), .N_WR(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

   assign bus0.r_addr = {ra[1], ra[0]};
   assign bus0.w_addr = {wa[1], wa[0]};
   assign bus0.w_data = {wd[1], wd[0]};
   assign bus0.w_en   = we;
   assign bus1.r_addr = {ra[1], ra[0]};
   assign bus1.w_addr = {wa[1], wa[0]};
   assign bus1.w_data = {wd[1], wd[0]};
   assign bus1.w_en   = we;

   logic done0, done1, err0, err1;

   mem_mp_init #(.N_ELEMENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_RD(2), .N_WR(2),
                 .RD_LATENCY(0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .init_done(done0), .err_oob(err0));
   mem_mp_init #(.N_ELEMENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_RD(2), .N_WR(2),
                 .RD_LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .init_done(done1), .err_oob(err1));

   // reference model
   logic [DW-1:0] m_mem [N];
   bit            m_ready;
   int            m_cnt;
   bit            m_err;
   logic [DW-1:0] m_rq [2];
   int vectors = 0;
   int miscompares = 0;

   function automatic logic [DW-1:0] image(int i);
      case (i)
         0: return 16'h200F;
         1: return 16'hEC18;
         2: return 16'h5A5A;
         3: return 16'h3C7E;
         4: return 16'h0F0F;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic [DW-1:0] m_read(int a);
      if (m_ready && a < N) return m_mem[a];
      return '0;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rd0(int p);
      return bus0.r_data[p*DW +: DW];
   endfunction
   function automatic logic [DW-1:0] rd1(int p);
      return bus1.r_data[p*DW +: DW];
   endfunction

   task automatic check_all();
      chk("init_done_l0", 32'(done0), 32'(m_ready));
      chk("init_done_l1", 32'(done1), 32'(m_ready));
      chk("err_oob_l0",   32'(err0),  32'(m_err));
      chk("err_oob_l1",   32'(err1),  32'(m_err));
      for (int p = 0; p < 2; p++) begin
         chk($sformatf("r_data_l0_p%0d@%0d", p, ra[p]), 32'(rd0(p)), 32'(m_read(int'(ra[p]))));
         chk($sformatf("r_data_l1_p%0d", p), 32'(rd1(p)), 32'(m_rq[p]));
      end
   endtask

   // One clock edge: advance the model from pre-edge inputs, then check.
   task automatic tick();
      logic [DW-1:0] pre [2];
      bit oob;
      for (int p = 0; p < 2; p++) pre[p] = m_read(int'(ra[p]));
      if (!rst) begin
         m_ready = 0; m_cnt = 0; m_err = 0;
         m_rq[0] = '0; m_rq[1] = '0;
      end else if (!m_ready) begin
         m_mem[m_cnt] = image(m_cnt);
         if (m_cnt == N - 1) m_ready = 1;
         else m_cnt++;
         m_rq = pre;
      end else begin
         oob = 0;
         for (int p = 0; p < 2; p++) if (ra[p] >= N) oob = 1;
         for (int j = 0; j < 2; j++) begin
            if (we[j] && wa[j] >= N) oob = 1;
            if (we[j] && wa[j] < N) m_mem[wa[j]] = wd[j];
         end
         if (oob) m_err = 1;
         m_rq = pre;
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic rand_in(int amax);
      for (int p = 0; p < 2; p++) begin
         ra[p] = AW'($urandom_range(0, amax));
         wa[p] = AW'($urandom_range(0, amax));
         wd[p] = DW'($urandom);
      end
      we = 2'($urandom);
   endtask

   initial begin
      we = '0; wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
      ra[0] = '0; ra[1] = '0;
      m_ready = 0; m_cnt = 0; m_err = 0; m_rq[0] = '0; m_rq[1] = '0;

      // reset held for two edges
      rst = 1'b0;
      tick(); tick();

      // init walk; writes and out-of-range accesses are ignored here
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         ra[0] = AW'($urandom_range(0, 31)); ra[1] = AW'($urandom_range(0, 31));
         we = 2'b11; wa[0] = 3; wd[0] = 16'hBEEF; wa[1] = 20; wd[1] = DW'($urandom);
         tick();
         if (i == N - 2) chk("done_low_at_15", 32'(done0), 32'd0);
      end
      chk("done_high_at_16", 32'(done0), 32'd1);
      we = 2'b00;

      ra[0] = 0; ra[1] = 1; tick();
      chk("img0", 32'(rd0(0)), 32'h200F);
      chk("img1", 32'(rd0(1)), 32'hEC18);
      ra[0] = 15; ra[1] = 3; tick();
      chk("img15", 32'(rd0(0)), 32'h0000);
      chk("img3_not_beef", 32'(rd0(1)), 32'h3C7E);
      chk("no_err_after_init", 32'(err0), 32'd0);

      // same-address conflict: port 1 wins
      we = 2'b11; wa[0] = 5; wa[1] = 5; wd[0] = 16'h1111; wd[1] = 16'h2222; ra[0] = 5;
      tick();
      chk("conflict_l0", 32'(rd0(0)), 32'h2222);
      we = 2'b00; tick();
      chk("conflict_l1", 32'(rd1(0)), 32'h2222);

      // read-during-write latency behaviour
      ra[1] = 7; tick();
      we = 2'b01; wa[0] = 7; wd[0] = 16'hABCD; tick();
      chk("rdw_l0_new", 32'(rd0(1)), 32'hABCD);
      chk("rdw_l1_old", 32'(rd1(1)), 32'(image(7)));
      we = 2'b00; tick();
      chk("rdw_l1_next", 32'(rd1(1)), 32'hABCD);

      for (int i = 0; i < 300; i++) begin rand_in(N - 1); tick(); end

      // out-of-range read and write
      we = 2'b00; ra[0] = 20; ra[1] = AW'($urandom_range(0, N - 1)); tick();
      chk("oob_rd_zero", 32'(rd0(0)), 32'd0);
      chk("oob_err_set", 32'(err0), 32'd1);
      we = 2'b11; wa[0] = 20; wa[1] = 20; wd[0] = DW'($urandom); wd[1] = DW'($urandom);
      ra[0] = 4; tick();
      we = 2'b00;
      for (int a = 0; a < N; a += 2) begin ra[0] = AW'(a); ra[1] = AW'(a + 1); tick(); end
      for (int i = 0; i < 60; i++) begin rand_in(31); tick(); end
      chk("oob_sticky", 32'(err1), 32'd1);

      // reset clears the flag; then reset mid-init at init_cnt=9
      rst = 1'b0; we = 2'b00; tick();
      chk("err_cleared", 32'(err0), 32'd0);
      rst = 1'b1;
      for (int i = 0; i < 9; i++) begin rand_in(31); tick(); end
      rst = 1'b0; tick();
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         rand_in(31); tick();
         if (i == N - 2) chk("restart_low_15", 32'(done1), 32'd0);
      end
      chk("restart_high_16", 32'(done1), 32'd1);
      for (int i = 0; i < 150; i++) begin rand_in(N + 2); tick(); end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
